// File: rtl/multicycle_control_unit_if.sv
// Bundle of control-unit signals shared between the multicycle control FSM
// and the datapath/memory it steers.
//
// Parameters:
//   RET_W        width of the retired-instruction counter
// Signals:
//   opcode       instruction[31:26] from the instruction register
//   memAck       memory completes the current request this cycle
//   memReq       memory request, held until memAck
//   memWrite     request is a write (valid with memReq)
//   iorD         address select: 0=PC, 1=ALUOut
//   irWrite      load instruction register
//   pcWrite      unconditional PC load
//   pcWriteCond  PC load if branch condition holds
//   bne          branch polarity: 1=not-equal, 0=equal
//   pcSrc        00=ALU result, 01=ALUOut, 10=jump address
//   aluSrcA      0=PC, 1=rs
//   aluSrcB      00=rt, 01=4, 10=ext imm, 11=imm<<2
//   aluOp        00=add, 01=sub, 10=funct, 11=or
//   regDst       00=rt, 01=rd, 10=r31
//   memToReg     00=ALUOut, 01=MDR, 10=PC, 11=imm<<16
//   regWrite     register file write enable
//   state        current FSM state (debug)
//   retired      retired-instruction count, wraps
//   memFault     handshake timeout (sticky)
//   illegal      unsupported opcode trapped (sticky)
// Modports: master = control unit, slave = datapath/memory side.
interface multicycle_control_unit_if #(
  parameter int unsigned RET_W = 16
);
  logic [5:0]       opcode;
  logic             memAck;
  logic             memReq;
  logic             memWrite;
  logic             iorD;
  logic             irWrite;
  logic             pcWrite;
  logic             pcWriteCond;
  logic             bne;
  logic [1:0]       pcSrc;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       aluOp;
  logic [1:0]       regDst;
  logic [1:0]       memToReg;
  logic             regWrite;
  logic [3:0]       state;
  logic [RET_W-1:0] retired;
  logic             memFault;
  logic             illegal;

  modport master (
    input  opcode, memAck,
    output memReq, memWrite, iorD, irWrite, pcWrite, pcWriteCond, bne,
           pcSrc, aluSrcA, aluSrcB, aluOp, regDst, memToReg, regWrite,
           state, retired, memFault, illegal
  );

  modport slave (
    output opcode, memAck,
    input  memReq, memWrite, iorD, irWrite, pcWrite, pcWriteCond, bne,
           pcSrc, aluSrcA, aluSrcB, aluOp, regDst, memToReg, regWrite,
           state, retired, memFault, illegal
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control unit (R, lw, sw, j, jal, beq, bne, ori, lui).
// Steps each instruction through fetch/decode/execute/memory/writeback over a
// shared datapath, talks to a variable-latency memory via memReq/memAck with
// a timeout, and counts retired instructions.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    multicycle_control_unit_if.master (opcode/memAck in, controls out)
// Parameters:
//   WAIT_LIMIT  req cycles without ack before entering FAULT (1..255)
//   RET_W       retired counter width
// Optional feature:
//   MCU_ILLEGAL_TRAP_EN  when defined, unsupported opcodes go to an absorbing
//                        TRAP state and raise illegal; otherwise they are NOPs.
module multicycle_control_unit #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned RET_W      = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB   = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ORIEX  = 4'd10, IWB   = 4'd11,
    LUI    = 4'd12, FAULT  = 4'd13, TRAP   = 4'd14
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;

  state_t           state_q, state_d;
  logic [7:0]       wait_q;
  logic [RET_W-1:0] retired_q;
  logic             req_state;
  logic             timeout;
  logic             retire;

  // Only the three request states look at memAck; elsewhere it is ignored.
  assign req_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  // The counter is about to reach WAIT_LIMIT on this un-acked cycle; an ack
  // in the same cycle still wins because each request state tests ack first.
  assign timeout   = req_state && !bus.memAck && (wait_q == 8'(WAIT_LIMIT - 1));

  assign bus.memReq   = req_state;
  assign bus.state    = state_q;
  assign bus.retired  = retired_q;
  assign bus.memFault = (state_q == FAULT);   // sticky: FAULT is absorbing
`ifdef MCU_ILLEGAL_TRAP_EN
  assign bus.illegal  = (state_q == TRAP);    // sticky: TRAP is absorbing
`else
  assign bus.illegal  = 1'b0;
`endif

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path
    // through the case statement leaves a signal unassigned (no latches).
    state_d         = state_q;
    retire          = 1'b0;
    bus.memWrite    = 1'b0;
    bus.iorD        = 1'b0;
    bus.irWrite     = 1'b0;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.bne         = 1'b0;
    bus.pcSrc       = 2'b00;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = 2'b00;
    bus.aluOp       = 2'b00;
    bus.regDst      = 2'b00;
    bus.memToReg    = 2'b00;
    bus.regWrite    = 1'b0;

    case (state_q)
      FETCH: begin
        bus.aluSrcB = 2'b01;
        bus.irWrite = bus.memAck;   // Mealy: load IR and PC+4 on the ack cycle
        bus.pcWrite = bus.memAck;
        if (bus.memAck)   state_d = DECODE;
        else if (timeout) state_d = FAULT;
      end
      DECODE: begin
        bus.aluSrcB = 2'b11;        // precompute branch target in ALUOut
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_R:           state_d = EXEC;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J, OP_JAL:   state_d = JUMP;
          OP_ORI:         state_d = ORIEX;
          OP_LUI:         state_d = LUI;
`ifdef MCU_ILLEGAL_TRAP_EN
          default:        state_d = TRAP;
`else
          default:        state_d = FETCH;   // NOP, not counted as retired
`endif
        endcase
      end
      MEMADR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        state_d     = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iorD = 1'b1;
        if (bus.memAck)   state_d = MEMWB;
        else if (timeout) state_d = FAULT;
      end
      MEMWB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 2'b01;
        state_d      = FETCH;
        retire       = 1'b1;
      end
      MEMWR: begin
        bus.iorD     = 1'b1;
        bus.memWrite = 1'b1;
        if (bus.memAck) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      EXEC: begin
        bus.aluSrcA = 1'b1;
        bus.aluOp   = 2'b10;
      end
      RWB: begin
        bus.regWrite = 1'b1;
        bus.regDst   = 2'b01;
        state_d      = FETCH;
        retire       = 1'b1;
      end
      BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.aluOp       = 2'b01;
        bus.pcWriteCond = 1'b1;
        bus.pcSrc       = 2'b01;
        bus.bne         = (bus.opcode == OP_BNE);
        state_d         = FETCH;
        retire          = 1'b1;
      end
      JUMP: begin
        bus.pcWrite = 1'b1;
        bus.pcSrc   = 2'b10;
        if (bus.opcode == OP_JAL) begin
          bus.regWrite = 1'b1;
          bus.regDst   = 2'b10;
          bus.memToReg = 2'b10;
        end
        state_d = FETCH;
        retire  = 1'b1;
      end
      ORIEX: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        bus.aluOp   = 2'b11;
      end
      IWB: begin
        bus.regWrite = 1'b1;
        state_d      = FETCH;
        retire       = 1'b1;
      end
      LUI: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 2'b11;
        state_d      = FETCH;
        retire       = 1'b1;
      end
      default: ;                     // FAULT, TRAP: absorbing, all strobes 0
    endcase

    // Single-cycle execute states fall through to their writeback.
    if (state_q == EXEC)  state_d = RWB;
    if (state_q == ORIEX) state_d = IWB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (state_d != state_q)        wait_q <= '0;
      else if (req_state && !bus.memAck) wait_q <= wait_q + 8'd1;
      if (retire) retired_q <= retired_q + RET_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. A driver walks randomized
// instructions through a path-level reference model and queues the expected
// per-cycle observation; a monitor pops and compares on every falling edge.
`timescale 1ns/1ps
module tb_multicycle_control_unit;
  localparam int WAIT_LIMIT = 15;
  localparam int RET_W      = 4;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_RWB = 7,
                 S_BRANCH = 8, S_JUMP = 9, S_ORIEX = 10, S_IWB = 11,
                 S_LUI = 12, S_FAULT = 13, S_TRAP = 14;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_ORI = 6'b001101, OP_LUI = 6'b001111;

  typedef struct packed {
    logic [3:0]       state;
    logic             mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, bne;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic             reg_write;
    logic [RET_W-1:0] retired;
    logic             mem_fault, illegal;
  } obs_t;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.RET_W(RET_W)) bus ();

  multicycle_control_unit #(.WAIT_LIMIT(WAIT_LIMIT), .RET_W(RET_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   retired_count = 0;
  obs_t exp_q[$];
  logic [5:0] legal_ops [9] = '{OP_R, OP_LW, OP_SW, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ORI, OP_LUI};

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.state = bus.state;           o.mem_req = bus.memReq;
    o.mem_write = bus.memWrite;    o.iord = bus.iorD;
    o.ir_write = bus.irWrite;      o.pc_write = bus.pcWrite;
    o.pc_write_cond = bus.pcWriteCond; o.bne = bus.bne;
    o.pc_src = bus.pcSrc;          o.alu_src_a = bus.aluSrcA;
    o.alu_src_b = bus.aluSrcB;     o.alu_op = bus.aluOp;
    o.reg_dst = bus.regDst;        o.mem_to_reg = bus.memToReg;
    o.reg_write = bus.regWrite;    o.retired = bus.retired;
    o.mem_fault = bus.memFault;    o.illegal = bus.illegal;
    return o;
  endfunction

  // Control word each state must present, straight from the state table.
  function automatic obs_t exp_obs(int st, logic [5:0] op, logic ack);
    obs_t e = '0;
    e.state   = 4'(st);
    e.retired = RET_W'(retired_count % (1 << RET_W));
    case (st)
      S_FETCH:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = ack; e.pc_write = ack; end
      S_DECODE: e.alu_src_b = 2'b11;
      S_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      S_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
      S_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
      S_MEMWR:  begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
      S_EXEC:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      S_RWB:    begin e.reg_write = 1; e.reg_dst = 2'b01; end
      S_BRANCH: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                      e.pc_src = 2'b01; e.bne = (op == OP_BNE); end
      S_JUMP:   begin e.pc_write = 1; e.pc_src = 2'b10;
                      if (op == OP_JAL) begin e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
                end
      S_ORIEX:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
      S_IWB:    e.reg_write = 1;
      S_LUI:    begin e.reg_write = 1; e.mem_to_reg = 2'b11; end
      S_FAULT:  e.mem_fault = 1;
      S_TRAP:   e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  // Sequence of states an instruction visits (ignoring memory waits).
  function automatic iq_t path_of(logic [5:0] op);
    iq_t p;
    p = {S_FETCH, S_DECODE};
    case (op)
      OP_LW:          p = {p, S_MEMADR, S_MEMRD, S_MEMWB};
      OP_SW:          p = {p, S_MEMADR, S_MEMWR};
      OP_R:           p = {p, S_EXEC, S_RWB};
      OP_ORI:         p = {p, S_ORIEX, S_IWB};
      OP_BEQ, OP_BNE: p.push_back(S_BRANCH);
      OP_J, OP_JAL:   p.push_back(S_JUMP);
      OP_LUI:         p.push_back(S_LUI);
      default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
        p.push_back(S_TRAP);
`endif
      end
    endcase
    return p;
  endfunction

  // One cycle: drive inputs, queue the expectation, advance past the edge.
  task automatic emit(int st, logic [5:0] op, logic ack, bit retires);
    bus.opcode = op;
    bus.memAck = ack;
    exp_q.push_back(exp_obs(st, op, ack));
    @(posedge clk); #1;
    if (retires) retired_count++;
  endtask

  // Run one instruction; limit < 0 means run to completion.
  task automatic run_instr(logic [5:0] op, int fwait, int mwait, int limit);
    iq_t p;
    int  n;
    bit  counts;
    p = path_of(op);
    n = 0;
    counts = (p[p.size()-1] != S_DECODE) && (p[p.size()-1] != S_TRAP);
    foreach (p[i]) begin
      int st;
      bit last;
      st   = p[i];
      last = (i == p.size() - 1) && counts;
      if (st == S_FETCH || st == S_MEMRD || st == S_MEMWR) begin
        int w;
        w = (st == S_FETCH) ? fwait : mwait;
        for (int k = 0; k <= w; k++) begin
          if (n == limit) return;
          emit(st, op, k == w, last && (k == w));
          n++;
        end
      end else begin
        if (n == limit) return;
        emit(st, op, 1'($urandom_range(0, 1)), last);
        n++;
      end
    end
  endtask

  // Asynchronous assert a cycle after the edge, release one cycle later.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.memAck = 1'b0;
    #1;
    retired_count = 0;
    check("reset_async", sample(), exp_obs(S_FETCH, 6'd0, 1'b0));
    @(posedge clk); #1;
    check("reset_held", sample(), exp_obs(S_FETCH, 6'd0, 1'b0));
    rst_n = 1'b1;
  endtask

  // Monitor: one expected record per cycle while out of reset.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle_state%0d", e.state), sample(), e);
      end
    end
  end

  initial begin
    logic [5:0] op;
    bus.opcode = 6'd0;
    bus.memAck = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Zero-wait lw, delayed-fetch R-type, bne, jal.
    run_instr(OP_LW, 0, 0, -1);
    run_instr(OP_R, 3, 0, -1);
    run_instr(OP_BNE, 0, 0, -1);
    run_instr(OP_JAL, 1, 0, -1);
    run_instr(OP_BEQ, 0, 0, -1);
    run_instr(OP_J, 0, 0, -1);

    // Ack arrives on the last allowed cycle: it must win over the timeout.
    run_instr(OP_LW, WAIT_LIMIT - 1, WAIT_LIMIT - 1, -1);
    run_instr(OP_SW, 0, WAIT_LIMIT - 1, -1);

    // 16 lui wraps the 4-bit retired counter back to its start value.
    for (int i = 0; i < 16; i++) run_instr(OP_LUI, 0, 0, -1);

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      op = legal_ops[$urandom_range(0, 8)];
`ifndef MCU_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) op = 6'b111111 ^ 6'($urandom_range(0, 3));
`endif
      run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(0, WAIT_LIMIT - 1) : $urandom_range(0, 2),
                $urandom_range(0, 4), -1);
    end

    // Reset in the middle of an lw: it must not be counted.
    run_instr(OP_LW, 1, 2, 4);
    do_reset();
    run_instr(OP_ORI, 0, 0, -1);
    run_instr(OP_R, 0, 0, -1);

    // Unsupported opcode.
`ifdef MCU_ILLEGAL_TRAP_EN
    run_instr(6'b111111, 0, 0, -1);
    repeat (3) emit(S_TRAP, 6'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
`else
    run_instr(6'b111111, 0, 0, -1);
    run_instr(OP_LUI, 0, 0, -1);
`endif

    // Memory never answers: FAULT after WAIT_LIMIT request cycles, sticky.
    for (int k = 0; k < WAIT_LIMIT; k++) emit(S_FETCH, 6'($urandom), 1'b0, 1'b0);
    repeat (4) emit(S_FAULT, 6'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    run_instr(OP_LW, 0, 0, -1);
    run_instr(OP_LUI, 0, 0, -1);

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequential successor to the single-cycle opcode decoder. It is a Moore/Mealy FSM that steps the MIPS subset (R-type, lw, sw, j, jal, beq, bne, ori, lui) through fetch, decode, execute, memory and writeback cycles over a shared datapath. It talks to a variable-latency memory through a req/ack handshake with a timeout, and counts retired instructions. It sits between the instruction register's opcode field and the multicycle datapath muxes/enables.

## Interface
- WAIT_LIMIT, 15: max cycles memReq may stay high without memAck before fault (1..255)
- RET_W, 16: width of retired-instruction counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from instruction register
- memAck  in  1  memory completes the current request this cycle
- memReq  out  1  memory request, held until memAck
- memWrite  out  1  request is a write (valid with memReq)
- iorD  out  1  address select: 0=PC, 1=ALUOut
- irWrite  out  1  load instruction register
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if branch condition holds
- bne  out  1  branch condition polarity: 1=not-equal, 0=equal
- pcSrc  out  2  00=ALU result, 01=ALUOut (target), 10=jump address
- aluSrcA  out  1  0=PC, 1=rs
- aluSrcB  out  2  00=rt, 01=const 4, 10=sign/zero-ext imm, 11=imm<<2
- aluOp  out  2  00=add, 01=sub, 10=funct field, 11=or
- regDst  out  2  00=rt, 01=rd, 10=r31
- memToReg  out  2  00=ALUOut, 01=MDR, 10=PC, 11=imm<<16
- regWrite  out  1  register file write enable
- state  out  4  current state encoding (debug)
- retired  out  RET_W  retired-instruction count, wraps
- memFault  out  1  sticky: handshake timeout
- illegal  out  1  sticky: unsupported opcode (only with trap macro)

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, j 000010, jal 000011, beq 000100, bne 000101, ori 001101, lui 001111.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ORIEX 10, IWB 11, LUI 12, FAULT 13, TRAP 14.
- FETCH: memReq=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00. irWrite=pcWrite=memAck (Mealy). On memAck go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state: lw/sw→MEMADR; R→EXEC; beq/bne→BRANCH; j/jal→JUMP; ori→ORIEX; lui→LUI; any other opcode→FETCH (treated as NOP).
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. lw→MEMRD, sw→MEMWR.
- MEMRD: memReq=1, iorD=1; on memAck go to MEMWB. MEMWB: regWrite, regDst=00, memToReg=01.
- MEMWR: memReq=1, memWrite=1, iorD=1; on memAck go to FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. RWB: regWrite, regDst=01, memToReg=00.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSrc=01, bne=(opcode==000101).
- JUMP: pcWrite=1, pcSrc=10. For jal also regWrite, regDst=10, memToReg=10.
- ORIEX: aluSrcA=1, aluSrcB=10 (zero-ext), aluOp=11. IWB: regWrite, regDst=00, memToReg=00.
- LUI: regWrite, regDst=00, memToReg=11.
- MEMWB, MEMWR(ack), RWB, BRANCH, JUMP, IWB and LUI return to FETCH and increment retired by 1; wrap from 2^RET_W-1 to 0. The DECODE NOP path does not increment retired.
- Wait counter: cleared on every state change. It increments each cycle memReq=1 and memAck=0. When it reaches WAIT_LIMIT, go to FAULT.
- FAULT: memFault=1, all strobes 0. Absorbing until reset.
- memAck is ignored whenever memReq=0.
- Unlisted outputs are 0 in each state.

## Timing
- Reset (async assert): state=FETCH, retired=0, waitCnt=0, memFault=0, illegal=0. memReq reads 1 immediately after reset because FETCH is the reset state. Every other output is 0.
- Zero-wait memory (memAck on the first req cycle): lw 5 cycles; sw 4; R 4; ori 4; beq/bne/j/jal/lui 3.
- Each memory wait cycle adds exactly one cycle.
- memAck on the cycle the counter reaches WAIT_LIMIT: the ack wins and the FSM advances with no fault.
- Reset mid-instruction aborts it; retired does not count it.

## Configuration
- MCU_ILLEGAL_TRAP_EN defined: DECODE on an unsupported opcode goes to TRAP. TRAP sets illegal=1 (sticky), drives all strobes 0, and is absorbing until reset.
- MCU_ILLEGAL_TRAP_EN undefined: TRAP is unreachable, illegal is tied 0, and unsupported opcodes are NOPs that return to FETCH.

## Test plan
- Reset, then memAck=1 every cycle, opcode=100011 (lw) → state sequence 0,1,2,3,4,0; retired=1 after 5 cycles; regWrite=1 with memToReg=01 only in state 4.
- Fetch with memAck delayed 3 cycles, then R-type → memReq held 4 cycles; irWrite pulses once on the ack cycle; retired=1 after 7 cycles.
- WAIT_LIMIT=15, memAck held 0 → FAULT after 15 req cycles; memFault=1 persists; rst_n low clears it.
- opcode=000101 → BRANCH with pcWriteCond=1, bne=1, aluOp=01. opcode=000011 → JUMP with pcWrite=1, regWrite=1, regDst=10, memToReg=10.
- opcode=111111: with MCU_ILLEGAL_TRAP_EN → state 14, illegal=1, retired unchanged. Without the macro → back to FETCH, illegal=0.
- RET_W=4: run 16 lui instructions → retired wraps 15→0.
